// File: rtl/cam_cmd_sequencer_if.sv
// Command/response handshake bundle between a host controller and cam_cmd_sequencer.
// The host side uses the master modport, the sequencer uses the slave modport.
interface cam_cmd_sequencer_if #(
    parameter int num_bits  = 16,
    parameter int num_cells = 5
);
    logic                 cmd_valid;
    logic                 cmd_ready;
    logic [1:0]           cmd_op;
    logic [num_bits-1:0]  cmd_data;
    logic [num_bits-1:0]  cmd_mask;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [num_cells-1:0] rsp_tags;
    logic                 rsp_any;
    logic [num_bits-1:0]  rsp_data;

    modport master (
        output cmd_valid, cmd_op, cmd_data, cmd_mask, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_tags, rsp_any, rsp_data
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_data, cmd_mask, rsp_ready,
        output cmd_ready, rsp_valid, rsp_tags, rsp_any, rsp_data
    );
endinterface

// File: rtl/cam_cmd_sequencer.sv
// Command-level initiator for the cam array: one op per handshake, phase-timed pins, one response beat.
// Optional feature: define CAM_MATCH_COUNT_EN to add the rsp_count popcount output.
module cam_cmd_sequencer #(
    parameter int num_bits      = 16,
    parameter int num_cells     = 5,
    parameter int set_cycles    = 2,
    parameter int search_cycles = 2,
    parameter int write_cycles  = 2
) (
    input  logic                      CLK,
    input  logic                      RST_N,
    cam_cmd_sequencer_if.slave        bus,
    output logic [num_bits-1:0]       comparand,
    output logic [num_bits-1:0]       mask,
    output logic                      set,
    output logic                      perform_search,
    output logic                      select_first,
    output logic [2*num_bits-1:0]     write_lines,
    input  logic [num_cells-1:0]      tag_wires,
    input  logic [num_bits-1:0]       read_lines
`ifdef CAM_MATCH_COUNT_EN
    ,
    output logic [$clog2(num_cells+1)-1:0] rsp_count
`endif
);

    localparam int MAX_SS  = (set_cycles > search_cycles) ? set_cycles : search_cycles;
    localparam int MAX_CYC = (MAX_SS > write_cycles) ? MAX_SS : write_cycles;
    localparam int PH_W    = $clog2(MAX_CYC + 1);

    localparam logic [1:0] OP_SEARCH = 2'd0;
    localparam logic [1:0] OP_SELECT = 2'd1;
    localparam logic [1:0] OP_WRITE  = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SET,
        ST_SRCH,
        ST_SEL,
        ST_WR,
        ST_RD,
        ST_RESP
    } state_t;

    state_t               state, state_nxt;
    logic [PH_W-1:0]      ph, ph_nxt;
    logic                 accept;
    logic                 snap;
    logic [num_bits-1:0]  op_data, op_mask;
    logic [num_bits-1:0]  comparand_r, mask_r;
    logic [num_cells-1:0] rsp_tags_r;
    logic                 rsp_any_r;
    logic [num_bits-1:0]  rsp_data_r;

    assign accept = (state == ST_IDLE) && bus.cmd_valid;

    // Next-state: each op state reloads its phase counter on entry and exits when it reaches 0.
    always_comb begin
        state_nxt = state;
        ph_nxt    = ph;
        snap      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.cmd_valid) begin
                    case (bus.cmd_op)
                        OP_SEARCH: begin
                            state_nxt = ST_SET;
                            ph_nxt    = PH_W'(set_cycles - 1);
                        end
                        OP_SELECT: begin
                            state_nxt = ST_SEL;
                            ph_nxt    = '0;
                        end
                        OP_WRITE: begin
                            state_nxt = ST_WR;
                            ph_nxt    = PH_W'(write_cycles - 1);
                        end
                        default: begin
                            state_nxt = ST_RD;
                            ph_nxt    = '0;
                        end
                    endcase
                end
            end
            ST_SET: begin
                if (ph == '0) begin
                    state_nxt = ST_SRCH;
                    ph_nxt    = PH_W'(search_cycles - 1);
                end else begin
                    ph_nxt = ph - 1'b1;
                end
            end
            ST_SRCH, ST_WR: begin
                if (ph == '0) begin
                    state_nxt = ST_RESP;
                    snap      = 1'b1;
                end else begin
                    ph_nxt = ph - 1'b1;
                end
            end
            ST_SEL, ST_RD: begin
                state_nxt = ST_RESP;
                snap      = 1'b1;
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                ph_nxt    = '0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= ST_IDLE;
            ph    <= '0;
        end else begin
            state <= state_nxt;
            ph    <= ph_nxt;
        end
    end

    // Command latch: comparand/mask only follow SEARCH so the cam keeps its last search key.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            op_data     <= '0;
            op_mask     <= '0;
            comparand_r <= '0;
            mask_r      <= '0;
        end else if (accept) begin
            op_data <= bus.cmd_data;
            op_mask <= bus.cmd_mask;
            if (bus.cmd_op == OP_SEARCH) begin
                comparand_r <= bus.cmd_data;
                mask_r      <= bus.cmd_mask;
            end
        end
    end

`ifdef CAM_MATCH_COUNT_EN
    function automatic logic [$clog2(num_cells+1)-1:0] popcount(input logic [num_cells-1:0] v);
        logic [$clog2(num_cells+1)-1:0] acc;
        acc = '0;
        for (int i = 0; i < num_cells; i++) begin
            acc = acc + {{($clog2(num_cells+1)-1){1'b0}}, v[i]};
        end
        return acc;
    endfunction

    logic [$clog2(num_cells+1)-1:0] rsp_count_r;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rsp_count_r <= '0;
        end else if (snap) begin
            rsp_count_r <= popcount(tag_wires);
        end
    end

    assign rsp_count = rsp_count_r;
`endif

    // Response snapshot on the last op cycle; held untouched through any RESP stall.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rsp_tags_r <= '0;
            rsp_any_r  <= 1'b0;
            rsp_data_r <= '0;
        end else if (snap) begin
            rsp_tags_r <= tag_wires;
            rsp_any_r  <= |tag_wires;
            rsp_data_r <= (state == ST_RD) ? read_lines : '0;
        end
    end

    // Pin drive is decoded from the state register, so async reset clears it immediately.
    assign set            = (state == ST_SET);
    assign perform_search = (state == ST_SRCH);
    assign select_first   = (state == ST_SEL);
    assign comparand      = comparand_r;
    assign mask           = mask_r;

    always_comb begin
        write_lines = '0;
        if (state == ST_WR) begin
            for (int i = 0; i < num_bits; i++) begin
                write_lines[2*i]   = op_data[i] & op_mask[i];
                write_lines[2*i+1] = ~op_data[i] & op_mask[i];
            end
        end
    end

    assign bus.cmd_ready = (state == ST_IDLE);
    assign bus.rsp_valid = (state == ST_RESP);
    assign bus.rsp_tags  = rsp_tags_r;
    assign bus.rsp_any   = rsp_any_r;
    assign bus.rsp_data  = rsp_data_r;

endmodule

// File: tb/tb_cam_cmd_sequencer.sv
// Directed scoreboard bench for cam_cmd_sequencer: pin timing, response payload, stalls, mid-op reset.
module tb_cam_cmd_sequencer;
    localparam int NB = 16;
    localparam int NC = 5;
    localparam int SC = 2;
    localparam int RC = 2;
    localparam int WC = 2;
    localparam int CW = $clog2(NC + 1);

    logic CLK = 1'b0;
    logic RST_N = 1'b0;
    always #5 CLK = ~CLK;

    cam_cmd_sequencer_if #(.num_bits(NB), .num_cells(NC)) bus ();

    logic [NB-1:0]   comparand, mask;
    logic            set, perform_search, select_first;
    logic [2*NB-1:0] write_lines;
    logic [NC-1:0]   tag_wires;
    logic [NB-1:0]   read_lines;
`ifdef CAM_MATCH_COUNT_EN
    logic [CW-1:0]   rsp_count;
`endif

    cam_cmd_sequencer #(
        .num_bits(NB), .num_cells(NC), .set_cycles(SC),
        .search_cycles(RC), .write_cycles(WC)
    ) dut (
        .CLK(CLK),
        .RST_N(RST_N),
        .bus(bus),
        .comparand(comparand),
        .mask(mask),
        .set(set),
        .perform_search(perform_search),
        .select_first(select_first),
        .write_lines(write_lines),
        .tag_wires(tag_wires),
        .read_lines(read_lines)
`ifdef CAM_MATCH_COUNT_EN
        ,
        .rsp_count(rsp_count)
`endif
    );

    typedef struct {
        logic [NC-1:0] tags;
        logic          any;
        logic [NB-1:0] data;
        logic [CW-1:0] cnt;
    } rsp_t;

    rsp_t sb[$];
    int n_cmp = 0;
    int n_mis = 0;
    logic [NB-1:0] last_cmp = '0;
    logic [NB-1:0] last_msk = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [CW-1:0] popcnt(input logic [NC-1:0] v);
        logic [CW-1:0] c;
        c = '0;
        for (int i = 0; i < NC; i++) if (v[i]) c = c + 1'b1;
        return c;
    endfunction

    function automatic logic [2*NB-1:0] wl_model(input logic [NB-1:0] d, input logic [NB-1:0] m);
        logic [2*NB-1:0] w;
        w = '0;
        for (int i = 0; i < NB; i++) begin
            if (m[i]) w[2*i +: 2] = d[i] ? 2'b01 : 2'b10;
        end
        return w;
    endfunction

    // One complete op: drive, measure pin pulses and latency, then check the response beat.
    task automatic run_op(input string nm, input logic [1:0] op, input logic [NB-1:0] d,
                          input logic [NB-1:0] m, input logic [NC-1:0] tags,
                          input logic [NB-1:0] rd, input logic [2*NB-1:0] exp_wl,
                          input int stall);
        rsp_t e, got;
        int lat, n_set, n_ps, n_sel, n_wr, n_bad;
        int exp_lat;
        tag_wires = tags;
        read_lines = rd;
        e.tags = tags;
        e.any  = |tags;
        e.data = (op == 2'd3) ? rd : '0;
        e.cnt  = popcnt(tags);
        sb.push_back(e);
        case (op)
            2'd0:    exp_lat = SC + RC + 1;
            2'd2:    exp_lat = WC + 1;
            default: exp_lat = 2;
        endcase

        chk({nm, "_cmd_ready_idle"}, bus.cmd_ready, 1'b1);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_data  = d;
        bus.cmd_mask  = m;
        tick();
        bus.cmd_valid = 1'b0;
        bus.cmd_data  = NB'($urandom);
        bus.cmd_mask  = NB'($urandom);
        if (op == 2'd0) begin
            last_cmp = d;
            last_msk = m;
        end
        chk({nm, "_comparand"}, {comparand, mask}, {last_cmp, last_msk});

        lat = 1; n_set = 0; n_ps = 0; n_sel = 0; n_wr = 0; n_bad = 0;
        while (bus.rsp_valid !== 1'b1 && lat < 20) begin
            if (set) n_set++;
            if (perform_search) n_ps++;
            if (select_first) n_sel++;
            if (write_lines != '0) begin
                n_wr++;
                if (write_lines !== exp_wl) n_bad++;
            end
            if ((int'(set) + int'(perform_search) + int'(select_first) + int'(write_lines != '0)) > 1)
                n_bad++;
            if (bus.cmd_ready !== 1'b0) n_bad++;
            tick();
            lat++;
        end
        chk({nm, "_latency"}, lat, exp_lat);
        chk({nm, "_pulses"}, {n_set[7:0], n_ps[7:0], n_sel[7:0], n_wr[7:0]},
            {8'((op == 2'd0) ? SC : 0), 8'((op == 2'd0) ? RC : 0),
             8'((op == 2'd1) ? 1 : 0), 8'((op == 2'd2) ? WC : 0)});
        chk({nm, "_pin_errors"}, n_bad, 0);
        if (bus.rsp_valid !== 1'b1) return;
        chk({nm, "_pins_idle_in_resp"}, {set, perform_search, select_first, write_lines}, '0);

        got = sb.pop_front();
        for (int c = 0; c < stall; c++) begin
            bus.cmd_valid = 1'b1;
            bus.cmd_op    = 2'd1;
            chk({nm, "_stall"}, {bus.rsp_valid, bus.cmd_ready, bus.rsp_tags, bus.rsp_any, bus.rsp_data},
                {1'b1, 1'b0, got.tags, got.any, got.data});
            tick();
        end
        bus.cmd_valid = 1'b0;

        chk({nm, "_rsp_tags"}, bus.rsp_tags, got.tags);
        chk({nm, "_rsp_any"}, bus.rsp_any, got.any);
        chk({nm, "_rsp_data"}, bus.rsp_data, got.data);
`ifdef CAM_MATCH_COUNT_EN
        chk({nm, "_rsp_count"}, rsp_count, got.cnt);
`endif
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        chk({nm, "_after_handshake"}, {bus.rsp_valid, bus.cmd_ready}, 2'b01);
    endtask

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = '0;
        bus.cmd_data  = '0;
        bus.cmd_mask  = '0;
        bus.rsp_ready = 1'b0;
        tag_wires     = '0;
        read_lines    = '0;

        #12;
        chk("reset_ready_valid", {bus.cmd_ready, bus.rsp_valid}, 2'b10);
        chk("reset_pins", {set, perform_search, select_first, write_lines}, '0);
        chk("reset_payload", {comparand, mask, bus.rsp_tags, bus.rsp_any, bus.rsp_data}, '0);
        @(negedge CLK);
        RST_N = 1'b1;
        tick();

        run_op("write_a5", 2'd2, 16'h00A5, 16'h00FF, 5'b01100, 16'h1111, 32'h00006699, 0);
        run_op("search_hit", 2'd0, 16'h0001, 16'hFFFF, 5'b10110, 16'h2222, '0, 0);
        run_op("write_f0", 2'd2, 16'hF0F0, 16'h0F3C, 5'b00001, 16'h0000,
               wl_model(16'hF0F0, 16'h0F3C), 0);
        run_op("select_first", 2'd1, 16'h5555, 16'hAAAA, 5'b00010, 16'h3333, '0, 0);
        run_op("read_beef", 2'd3, 16'h0000, 16'h0000, 5'b00000, 16'hBEEF, '0, 0);
        run_op("search_miss_stall", 2'd0, 16'h1234, 16'h00FF, 5'b00000, 16'h4444, '0, 10);
        run_op("read_after_stall", 2'd3, 16'h0000, 16'h0000, 5'b11111, 16'h1357, '0, 0);

        // Reset in the middle of a SEARCH.
        tag_wires = 5'b00111;
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 2'd0;
        bus.cmd_data  = 16'hCAFE;
        bus.cmd_mask  = 16'hF00F;
        tick();
        bus.cmd_valid = 1'b0;
        tick();
        chk("midop_set_active", set, 1'b1);
        #2;
        RST_N = 1'b0;
        #1;
        chk("midop_reset_pins", {set, perform_search, bus.rsp_valid}, 3'b000);
        @(negedge CLK);
        RST_N = 1'b1;
        tick();
        chk("after_reset_ready", {bus.cmd_ready, bus.rsp_valid}, 2'b10);
        last_cmp = '0;
        last_msk = '0;
        chk("after_reset_comparand", {comparand, mask}, '0);

        run_op("search_recover", 2'd0, 16'h00F0, 16'h0FF0, 5'b01000, 16'h0000, '0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "bench timeout");
    end
endmodule
